// File: rtl/syscall_sequencer.sv
// Syscall sequencer: stalls fetch/decode, drains in-flight writes, captures
// v0/a0/a1 and either services the call over a valid/ready channel or halts.
module syscall_sequencer #(
  parameter int unsigned DRAIN_CYCLES    = 3,
  parameter logic [31:0] CODE_PRINT_INT  = 32'd1,
  parameter logic [31:0] CODE_PRINT_STR  = 32'd4,
  parameter logic [31:0] CODE_EXIT       = 32'd10,
  parameter logic [31:0] CODE_PRINT_CHAR = 32'd11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        syscall_d,
  input  logic [31:0] v0_in,
  input  logic [31:0] a0_in,
  input  logic [31:0] a1_in,
  output logic        stall_fd,
  output logic        flush_e,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_code,
  output logic [31:0] out_data,
  output logic [31:0] out_aux,
  output logic        unsupported,
  output logic        done,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_IDLE, S_DRAIN, S_CAPTURE, S_SEND, S_RELEASE, S_HALT
  } state_t;

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] code_q, code_d, data_q, data_d, aux_q, aux_d;
  logic        valid_q, valid_d, unsup_q, unsup_d, done_q, done_d, halted_q, halted_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    data_d  = data_q;
    aux_d   = aux_q;
    unsup_d = 1'b0;
    case (state_q)
      S_IDLE:    if (syscall_d) begin
                   state_d = S_DRAIN;
                   cnt_d   = DRAIN_LOAD;
                 end
      S_DRAIN:   if (cnt_q == 4'd0) state_d = S_CAPTURE;
                 else               cnt_d   = cnt_q - 4'd1;
      S_CAPTURE: begin
        code_d = v0_in;
        data_d = a0_in;
        aux_d  = a1_in;
        if (v0_in == CODE_EXIT)
          state_d = S_HALT;
        else if (v0_in == CODE_PRINT_INT || v0_in == CODE_PRINT_STR ||
                 v0_in == CODE_PRINT_CHAR)
          state_d = S_SEND;
        else begin
          state_d = S_RELEASE;
          unsup_d = 1'b1;
        end
      end
      S_SEND:    if (out_ready) state_d = S_RELEASE;
      // syscall_d still shows the retiring syscall here, so it is not sampled
      S_RELEASE: state_d = S_IDLE;
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_IDLE;
    endcase
    // Status outputs are registered copies of the state being entered
    valid_d  = (state_d == S_SEND);
    done_d   = (state_d == S_RELEASE);
    halted_d = (state_d == S_HALT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      code_q   <= 32'd0;
      data_q   <= 32'd0;
      aux_q    <= 32'd0;
      valid_q  <= 1'b0;
      unsup_q  <= 1'b0;
      done_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      code_q   <= code_d;
      data_q   <= data_d;
      aux_q    <= aux_d;
      valid_q  <= valid_d;
      unsup_q  <= unsup_d;
      done_q   <= done_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    stall_fd = 1'b0;
    case (state_q)
      S_IDLE:                             stall_fd = syscall_d;
      S_DRAIN, S_CAPTURE, S_SEND, S_HALT: stall_fd = 1'b1;
      default:                            stall_fd = 1'b0;
    endcase
  end

  assign flush_e     = stall_fd;
  assign out_valid   = valid_q;
  assign out_code    = code_q;
  assign out_data    = data_q;
  assign out_aux     = aux_q;
  assign unsupported = unsup_q;
  assign done        = done_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_syscall_sequencer.sv
// Randomized bench for syscall_sequencer; expectations come from a per-call
// timeline derived from the drain length and the consumer's ready delay.
module tb_syscall_sequencer;
  localparam int D = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        syscall_d = 1'b0;
  logic [31:0] v0_in = '0, a0_in = '0, a1_in = '0;
  logic        out_ready = 1'b0;
  logic        stall_fd, flush_e, out_valid, unsupported, done, halted;
  logic [31:0] out_code, out_data, out_aux;

  int n_checks = 0;
  int n_fail   = 0;

  syscall_sequencer #(.DRAIN_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .syscall_d(syscall_d),
    .v0_in(v0_in), .a0_in(a0_in), .a1_in(a1_in),
    .stall_fd(stall_fd), .flush_e(flush_e),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_code(out_code), .out_data(out_data), .out_aux(out_aux),
    .unsupported(unsupported), .done(done), .halted(halted)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One syscall from its first decode cycle (k=0) to retirement. kind: 0 serviced,
  // 1 unsupported, 2 exit. w = SEND cycles with out_ready low before acceptance.
  task automatic run_call(input logic [31:0] code, input logic [31:0] a0,
                          input logic [31:0] a1, input int w, input bit ready_hold);
    int  kind, last;
    bit  e_stall, e_valid, e_done, e_unsup, e_halt;
    kind = (code == 1 || code == 4 || code == 11) ? 0 : (code == 10) ? 2 : 1;
    last = (kind == 0) ? D + 3 + w : (kind == 1) ? D + 2 : D + 22;
    for (int k = 0; k <= last; k++) begin
      syscall_d = (kind == 2 && k > D + 1) ? 1'($urandom) : 1'b1;
      if (ready_hold)                  out_ready = 1'b1;
      else if (kind == 0 && k >= D + 2) out_ready = (k >= D + 2 + w);
      else                             out_ready = 1'($urandom);
      v0_in = (k == D + 1) ? code : $urandom;
      a0_in = (k == D + 1) ? a0   : $urandom;
      a1_in = (k == D + 1) ? a1   : $urandom;
      case (kind)
        0: begin
          e_stall = (k <= D + 2 + w); e_valid = (k >= D + 2 && k <= D + 2 + w);
          e_done = (k == D + 3 + w);  e_unsup = 0; e_halt = 0;
        end
        1: begin
          e_stall = (k <= D + 1); e_valid = 0; e_done = (k == D + 2);
          e_unsup = (k == D + 2); e_halt = 0;
        end
        default: begin
          e_stall = 1; e_valid = 0; e_done = 0; e_unsup = 0; e_halt = (k >= D + 2);
        end
      endcase
      @(negedge clk);
      n_checks++; if (stall_fd !== e_stall) begin n_fail++; $display("FAIL stall_fd code=%0d k=%0d got %b exp %b", code, k, stall_fd, e_stall); end
      n_checks++; if (flush_e !== e_stall) begin n_fail++; $display("FAIL flush_e code=%0d k=%0d got %b exp %b", code, k, flush_e, e_stall); end
      n_checks++; if (out_valid !== e_valid) begin n_fail++; $display("FAIL out_valid code=%0d k=%0d got %b exp %b", code, k, out_valid, e_valid); end
      n_checks++; if (done !== e_done) begin n_fail++; $display("FAIL done code=%0d k=%0d got %b exp %b", code, k, done, e_done); end
      n_checks++; if (unsupported !== e_unsup) begin n_fail++; $display("FAIL unsupported code=%0d k=%0d got %b exp %b", code, k, unsupported, e_unsup); end
      n_checks++; if (halted !== e_halt) begin n_fail++; $display("FAIL halted code=%0d k=%0d got %b exp %b", code, k, halted, e_halt); end
      if (e_valid || e_unsup) begin
        n_checks++; if (out_code !== code) begin n_fail++; $display("FAIL out_code k=%0d got %h exp %h", k, out_code, code); end
        n_checks++; if (out_data !== a0) begin n_fail++; $display("FAIL out_data k=%0d got %h exp %h", k, out_data, a0); end
        n_checks++; if (out_aux !== a1) begin n_fail++; $display("FAIL out_aux k=%0d got %h exp %h", k, out_aux, a1); end
      end
      @(posedge clk); #1;
    end
    syscall_d = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_checks++; if ({stall_fd, flush_e, out_valid, unsupported, done, halted} !== 6'b0) begin n_fail++; $display("FAIL reset_flags got %b exp 000000", {stall_fd, flush_e, out_valid, unsupported, done, halted}); end
    n_checks++; if ({out_code, out_data, out_aux} !== 96'b0) begin n_fail++; $display("FAIL reset_data got %h exp 0", {out_code, out_data, out_aux}); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if ({stall_fd, out_valid, done, halted} !== 4'b0) begin n_fail++; $display("FAIL idle_after_reset got %b exp 0000", {stall_fd, out_valid, done, halted}); end
    @(posedge clk); #1;
  endtask

  task automatic test_print_int();
    run_call(32'd1, 32'h0000002A, $urandom, 0, 1'b1);
    @(negedge clk);
    n_checks++; if ({stall_fd, out_valid, done} !== 3'b0) begin n_fail++; $display("FAIL print_int_after got %b exp 000", {stall_fd, out_valid, done}); end
    @(posedge clk); #1;
  endtask

  task automatic test_print_char_wait();
    run_call(32'd11, 32'h00000041, $urandom, 4, 1'b0);
  endtask

  task automatic test_exit_halt();
    run_call(32'd10, $urandom, $urandom, 0, 1'b0);
    syscall_d = 1'b0;
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    n_checks++; if ({stall_fd, flush_e, out_valid, unsupported, done, halted} !== 6'b0) begin n_fail++; $display("FAIL async_reset_flags got %b exp 000000", {stall_fd, flush_e, out_valid, unsupported, done, halted}); end
    n_checks++; if ({out_code, out_data, out_aux} !== 96'b0) begin n_fail++; $display("FAIL async_reset_data got %h exp 0", {out_code, out_data, out_aux}); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_unsupported();
    run_call(32'd7, $urandom, $urandom, 0, 1'b0);
    run_call(32'd1, $urandom, $urandom, 1, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_call(32'd1, $urandom, $urandom, 0, 1'b1);
    run_call(32'd4, 32'h10010000, $urandom, 2, 1'b0);
  endtask

  task automatic test_reset_in_send();
    syscall_d = 1'b1; out_ready = 1'b0;
    v0_in = 32'd1; a0_in = 32'h55; a1_in = 32'h66;
    for (int k = 0; k < D + 3; k++) begin @(posedge clk); #1; end
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL send_before_reset got %b exp 1", out_valid); end
    #2;
    rst = 1'b1; syscall_d = 1'b0;
    #1;
    n_checks++; if ({out_valid, stall_fd, done} !== 3'b0) begin n_fail++; $display("FAIL reset_in_send got %b exp 000", {out_valid, stall_fd, done}); end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      out_ready = 1'($urandom);
      @(negedge clk);
      n_checks++; if ({out_valid, stall_fd, done} !== 3'b0) begin n_fail++; $display("FAIL post_reset_idle k=%0d got %b exp 000", k, {out_valid, stall_fd, done}); end
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    run_call(32'd4, $urandom, $urandom, 1, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] codes [5];
    logic [31:0] c;
    int gap;
    codes = '{32'd1, 32'd4, 32'd11, 32'd7, 32'd0};
    for (int i = 0; i < 15; i++) begin
      c = codes[$urandom_range(0, 4)];
      if (c == 0) begin
        c = $urandom;
        if (c == 1 || c == 4 || c == 10 || c == 11) c = 32'd99;
      end
      run_call(c, $urandom, $urandom, $urandom_range(0, 5), 1'b0);
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        out_ready = 1'($urandom); v0_in = $urandom;
        @(negedge clk);
        n_checks++; if ({stall_fd, out_valid, done} !== 3'b0) begin n_fail++; $display("FAIL idle_gap i=%0d got %b exp 000", i, {stall_fd, out_valid, done}); end
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_print_int();
    test_print_char_wait();
    test_exit_halt();
    test_unsupported();
    test_back_to_back();
    test_reset_in_send();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
